// File: rtl/frame_animator.sv
// Display-compositing stage: passes game frames through to the LED driver, or plays a
// death-flash / win-sweep animation. Optional macro FRAME_ANIMATOR_DEATH_ROW_EN lights the collision row.
//
// state | meaning
// PLAY  | registered pass-through of cars (red) and frog (green)
// DEATH | flash snapshot on even phases, blank on odd phases, busy high
// WIN   | sweep a full green row from 0 to 15, one row per tick, busy high
module frame_animator #(
   parameter int TICKS_PER_PHASE = 25,
   parameter int FLASH_COUNT     = 3
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               tick,
   input  logic [15:0][15:0]  cars,
   input  logic [15:0][15:0]  frog,
   input  logic               win,
   input  logic               lose,
   output logic [15:0][15:0]  red_out,
   output logic [15:0][15:0]  grn_out,
   output logic               busy
);

   localparam int PHASES = 2 * FLASH_COUNT;

   typedef enum logic [1:0] {PLAY, DEATH, WIN} state_t;

   state_t            state, state_nx;
   logic [7:0]        tick_cnt, tick_cnt_nx;
   logic [4:0]        phase_cnt, phase_nx, phase_inc;
   logic [3:0]        sweep_row, sweep_nx;
   logic [15:0][15:0] snapshot, snap_nx;
   logic [15:0][15:0] red_nx, grn_nx;
   logic [15:0][15:0] on_cur, on_entry;
   logic              busy_nx;

   assign phase_inc = phase_cnt + 5'd1;

`ifdef FRAME_ANIMATOR_DEATH_ROW_EN
   logic [3:0] death_row, frog_row;

   always_comb begin
      frog_row = 4'd0;
      for (int i = 0; i < 16; i++)
         if (|frog[i]) frog_row = 4'(i);
   end

   always_comb begin
      on_cur              = snapshot;
      on_cur[death_row]   = '1;
      on_entry            = cars | frog;
      on_entry[frog_row]  = '1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         death_row <= 4'd0;
      else if (state == PLAY && lose)
         death_row <= frog_row;
   end
`else
   always_comb begin
      on_cur   = snapshot;
      on_entry = cars | frog;
   end
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= PLAY;
         tick_cnt  <= 8'd0;
         phase_cnt <= 5'd0;
         sweep_row <= 4'd0;
         snapshot  <= '0;
         red_out   <= '0;
         grn_out   <= '0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nx;
         tick_cnt  <= tick_cnt_nx;
         phase_cnt <= phase_nx;
         sweep_row <= sweep_nx;
         snapshot  <= snap_nx;
         red_out   <= red_nx;
         grn_out   <= grn_nx;
         busy      <= busy_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      tick_cnt_nx = tick_cnt;
      phase_nx    = phase_cnt;
      sweep_nx    = sweep_row;
      snap_nx     = snapshot;
      red_nx      = red_out;
      grn_nx      = grn_out;
      busy_nx     = busy;
      case (state)
         PLAY: begin
            red_nx  = cars;
            grn_nx  = frog;
            busy_nx = 1'b0;
            if (lose) begin
               state_nx    = DEATH;
               busy_nx     = 1'b1;
               tick_cnt_nx = 8'd0;
               phase_nx    = 5'd0;
               snap_nx     = cars | frog;
               red_nx      = on_entry;
               grn_nx      = '0;
            end else if (win) begin
               state_nx    = WIN;
               busy_nx     = 1'b1;
               tick_cnt_nx = 8'd0;
               phase_nx    = 5'd0;
               sweep_nx    = 4'd0;
               red_nx      = '0;
               grn_nx      = '0;
               grn_nx[0]   = '1;
            end
         end
         DEATH: begin
            if (tick) begin
               if (tick_cnt == 8'(TICKS_PER_PHASE - 1)) begin
                  tick_cnt_nx = 8'd0;
                  if (phase_inc == 5'(PHASES)) begin
                     state_nx = PLAY;
                     phase_nx = 5'd0;
                     busy_nx  = 1'b0;
                     red_nx   = cars;
                     grn_nx   = frog;
                  end else begin
                     phase_nx = phase_inc;
                     red_nx   = phase_inc[0] ? '0 : on_cur;
                     grn_nx   = '0;
                  end
               end else begin
                  tick_cnt_nx = tick_cnt + 8'd1;
               end
            end
         end
         WIN: begin
            if (tick) begin
               if (sweep_row == 4'd15) begin
                  state_nx = PLAY;
                  sweep_nx = 4'd0;
                  busy_nx  = 1'b0;
                  red_nx   = cars;
                  grn_nx   = frog;
               end else begin
                  sweep_nx             = sweep_row + 4'd1;
                  red_nx               = '0;
                  grn_nx               = '0;
                  grn_nx[sweep_nx]     = '1;
               end
            end
         end
         default: state_nx = PLAY;
      endcase
   end

endmodule
